// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: stage occupancy state
// and the width of the per-stage stall counter.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'b00,
      PS_HALF  = 2'b01,
      PS_FULL  = 2'b10
   } pipe_state_e;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, synchronous clr.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter bit SKID           = 1'b1,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   pipe_state_e      state_reg, state_next;
   logic [WIDTH-1:0] main_reg, main_next;
   logic [WIDTH-1:0] skid_reg;
   logic             ready_raw;
   logic             in_fire, out_fire;

   generate
      if (SKID) begin : g_ready_reg
         assign ready_raw = (state_reg != PS_FULL);
      end else begin : g_ready_comb
         assign ready_raw = (state_reg == PS_EMPTY) | out_ready;
      end
   endgenerate

   // Reset gates in_ready so upstream never fires into a stage being cleared.
   assign in_ready  = rst & ready_raw;
   assign out_valid = (state_reg != PS_EMPTY);
   assign out_data  = main_reg;
   assign occupancy = state_reg;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      if (flush) begin
         state_next = PS_EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_next = '0;
         end
      end else begin
         case (state_reg)
            PS_EMPTY: begin
               if (in_fire) begin
                  main_next  = in_data;
                  state_next = PS_HALF;
               end
            end
            PS_HALF: begin
               if (in_fire && out_fire) begin
                  main_next = in_data;
               end else if (in_fire) begin
                  state_next = PS_FULL;
               end else if (out_fire) begin
                  state_next = PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  main_next  = skid_reg;
                  state_next = PS_HALF;
               end
            end
            default: state_next = PS_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= PS_EMPTY;
         main_reg  <= '0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic skid_load;

         // Second entry is only taken while the main entry is stuck downstream.
         assign skid_load = (state_reg == PS_HALF) & in_fire & ~out_fire & ~flush;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               skid_reg <= '0;
            end else if (flush && CLEAR_ON_FLUSH) begin
               skid_reg <= '0;
            end else if (skid_load) begin
               skid_reg <= in_data;
            end
         end
      end else begin : g_no_skid
         assign skid_reg = '0;
      end
   endgenerate

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .clr   (1'b0),
      .count (stall_cnt)
   );

endmodule
